pl_adc_stream_capture: RTL and testbench

- Parametrised successor to the fixed-length CMOS ADC capture block.
- On a start request it captures a run-time-programmable number of samples from the parallel CMOS ADC bus, with optional decimation and built-in test sources.
- Samples go through a small FWFT FIFO to a valid/ready stream with a last marker, feeding the PL DMA/stream master.
- Reports done, busy and overflow status to the PS-side control logic.

---
 rtl/pl_adc_stream_capture.sv | 269 ++++++++++++++++++++++++++
 tb/tb_pl_adc_stream_capture.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pl_adc_stream_capture.sv
`timescale 1ns/1ps
// pl_adc_stream_capture
// Captures a run-time-programmable number of samples (live ADC, fixed test
// pattern or ramp), optionally decimated, into a small first-word-fall-through
// FIFO that feeds a valid/ready stream with a last marker. Samples that find
// the FIFO nearly full are dropped and counted. The final sample of a run
// always has a reserved entry, so the last marker is never lost.

module pl_adc_stream_capture #(
  parameter int          DATA_WIDTH   = 12,
  parameter int          COUNT_WIDTH  = 20,
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [11:0] TEST_PATTERN = 12'h929
) (
  input  logic                   i_CMOS_Clk,
  input  logic                   i_Rst_n,
  input  logic [DATA_WIDTH-1:0]  i_CMOS_Data,
  input  logic                   i_ADC_Work,
  input  logic [COUNT_WIDTH-1:0] i_Sample_Count,
  input  logic [7:0]             i_Decim,
  input  logic [1:0]             i_Mode,
  output logic [DATA_WIDTH-1:0]  o_Data,
  output logic                   o_Valid,
  input  logic                   i_Ready,
  output logic                   o_Last,
  output logic                   o_ADC_Busy,
  output logic                   o_ADC_Done,
  output logic                   o_Overflow,
  output logic [15:0]            o_Drop_Count
);

  localparam int OCC_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int WORD_W = DATA_WIDTH + 1;

  localparam logic [OCC_W-1:0]       OCC_ZERO    = {OCC_W{1'b0}};
  localparam logic [OCC_W-1:0]       OCC_ONE     = OCC_W'(1);
  localparam logic [OCC_W-1:0]       OCC_FULL_M1 = OCC_W'(FIFO_DEPTH - 1);
  localparam logic [COUNT_WIDTH-1:0] IDX_ZERO    = {COUNT_WIDTH{1'b0}};
  localparam logic [COUNT_WIDTH-1:0] IDX_ONE     = COUNT_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0]  PAT_VAL     = DATA_WIDTH'(TEST_PATTERN);
  localparam logic [1:0]             MODE_PAT    = 2'b01;
  localparam logic [1:0]             MODE_RAMP   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [COUNT_WIDTH-1:0]  n_q, n_d;
  logic [7:0]              decim_q, decim_d;
  logic [1:0]              mode_q, mode_d;
  logic [7:0]              dcnt_q, dcnt_d;
  logic [COUNT_WIDTH-1:0]  idx_q, idx_d;
  logic                    ovf_q, ovf_d;
  logic [15:0]             drop_q, drop_d;
  logic                    done_q, done_d;
  logic                    valid_q, valid_d;
  logic [OCC_W-1:0]        occ_q, occ_d;
  logic [WORD_W-1:0]       fifo_q [FIFO_DEPTH];
  logic [WORD_W-1:0]       fifo_d [FIFO_DEPTH];
  logic [WORD_W-1:0]       shift_s [FIFO_DEPTH];

  logic                    start_s;
  logic                    slot_s;
  logic                    last_s;
  logic                    pop_s;
  logic                    push_s;
  logic                    drop_s;
  logic                    busy_s;
  logic [DATA_WIDTH-1:0]   slot_val_s;
  logic [OCC_W-1:0]        wr_idx_s;

  // A start is a work request seen while idle; a slot is a capture cycle with the decimation counter at zero.
  assign start_s  = (state_q == ST_IDLE) && i_ADC_Work;
  assign slot_s   = (state_q == ST_CAPTURE) && (dcnt_q == 8'd0);
  assign last_s   = slot_s && (idx_q == (n_q - IDX_ONE));
  assign pop_s    = valid_q && i_Ready;
  // One entry is held back for the final sample, so only non-last slots can be dropped.
  assign push_s   = slot_s && (last_s || (occ_q < OCC_FULL_M1));
  assign drop_s   = slot_s && !push_s;
  assign wr_idx_s = pop_s ? (occ_q - OCC_ONE) : occ_q;

  // FSM state register.
  always_ff @(posedge i_CMOS_Clk) begin
    if (!i_Rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (i_ADC_Work) begin
          if (i_Sample_Count == IDX_ZERO) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_CAPTURE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        if (last_s) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_DRAIN: begin
        if (pop_s && fifo_q[0][DATA_WIDTH]) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        if (!i_ADC_Work) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: busy straight from state, done registered from the next state.
  always_comb begin
    busy_s = 1'b0;
    done_d = 1'b0;
    case (state_q)
      ST_CAPTURE: busy_s = 1'b1;
      ST_DRAIN:   busy_s = 1'b1;
      default:    busy_s = 1'b0;
    endcase
    if (state_d == ST_DONE) begin
      done_d = 1'b1;
    end else begin
      done_d = 1'b0;
    end
  end

  // Select the value captured at a slot from the latched source mode.
  always_comb begin
    slot_val_s = i_CMOS_Data;
    case (mode_q)
      MODE_PAT:  slot_val_s = PAT_VAL;
      MODE_RAMP: slot_val_s = DATA_WIDTH'(idx_q);
      default:   slot_val_s = i_CMOS_Data;
    endcase
  end

  // Run bookkeeping: latch config at start, then advance decimation, index and drop tracking.
  always_comb begin
    n_d     = n_q;
    decim_d = decim_q;
    mode_d  = mode_q;
    dcnt_d  = dcnt_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q;
    drop_d  = drop_q;
    if (start_s) begin
      n_d     = i_Sample_Count;
      decim_d = i_Decim;
      mode_d  = i_Mode;
      dcnt_d  = 8'd0;
      idx_d   = IDX_ZERO;
      ovf_d   = 1'b0;
      drop_d  = 16'd0;
    end else if (state_q == ST_CAPTURE) begin
      if (dcnt_q == decim_q) begin
        dcnt_d = 8'd0;
      end else begin
        dcnt_d = dcnt_q + 8'd1;
      end
      if (slot_s) begin
        idx_d = idx_q + IDX_ONE;
      end else begin
        idx_d = idx_q;
      end
      if (drop_s) begin
        ovf_d = 1'b1;
        if (drop_q != 16'hFFFF) begin
          drop_d = drop_q + 16'd1;
        end else begin
          drop_d = drop_q;
        end
      end else begin
        ovf_d  = ovf_q;
        drop_d = drop_q;
      end
    end else begin
      dcnt_d = dcnt_q;
    end
  end

  // Head-aligned FIFO: a pop shifts every entry toward the output register, a push lands behind the last valid word.
  always_comb begin
    for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
      shift_s[i] = fifo_q[i+1];
    end
    shift_s[FIFO_DEPTH-1] = fifo_q[FIFO_DEPTH-1];
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (push_s && (OCC_W'(i) == wr_idx_s)) begin
        fifo_d[i] = {last_s, slot_val_s};
      end else if (pop_s) begin
        fifo_d[i] = shift_s[i];
      end else begin
        fifo_d[i] = fifo_q[i];
      end
    end
    if (push_s && !pop_s) begin
      occ_d = occ_q + OCC_ONE;
    end else if (pop_s && !push_s) begin
      occ_d = occ_q - OCC_ONE;
    end else begin
      occ_d = occ_q;
    end
    valid_d = (occ_d != OCC_ZERO);
  end

  // Datapath and FIFO registers.
  always_ff @(posedge i_CMOS_Clk) begin
    if (!i_Rst_n) begin
      n_q     <= IDX_ZERO;
      decim_q <= 8'd0;
      mode_q  <= 2'b00;
      dcnt_q  <= 8'd0;
      idx_q   <= IDX_ZERO;
      ovf_q   <= 1'b0;
      drop_q  <= 16'd0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      occ_q   <= OCC_ZERO;
      fifo_q  <= '{default: {WORD_W{1'b0}}};
    end else begin
      n_q     <= n_d;
      decim_q <= decim_d;
      mode_q  <= mode_d;
      dcnt_q  <= dcnt_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      occ_q   <= occ_d;
      fifo_q  <= fifo_d;
    end
  end

  assign o_Data       = fifo_q[0][DATA_WIDTH-1:0];
  assign o_Last       = fifo_q[0][DATA_WIDTH];
  assign o_Valid      = valid_q;
  assign o_ADC_Busy   = busy_s;
  assign o_ADC_Done   = done_q;
  assign o_Overflow   = ovf_q;
  assign o_Drop_Count = drop_q;

endmodule

// File: tb/tb_pl_adc_stream_capture.sv
`timescale 1ns/1ps
// Self-checking bench for pl_adc_stream_capture: randomized stimulus, a
// behavioural run model feeding an expected-word queue, and a monitor that
// compares every presented beat and the status outputs each cycle.

module tb_pl_adc_stream_capture;

  localparam int DW    = 12;
  localparam int CW    = 20;
  localparam int DEPTH = 16;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] cmos_data;
  logic          work;
  logic [CW-1:0] sample_count;
  logic [7:0]    decim;
  logic [1:0]    mode;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          ready;
  logic          last_o;
  logic          busy_o;
  logic          done_o;
  logic          ovf_o;
  logic [15:0]   drops_o;

  pl_adc_stream_capture #(
    .DATA_WIDTH  (DW),
    .COUNT_WIDTH (CW),
    .FIFO_DEPTH  (DEPTH),
    .TEST_PATTERN(12'h929)
  ) dut (
    .i_CMOS_Clk    (clk),
    .i_Rst_n       (rst_n),
    .i_CMOS_Data   (cmos_data),
    .i_ADC_Work    (work),
    .i_Sample_Count(sample_count),
    .i_Decim       (decim),
    .i_Mode        (mode),
    .o_Data        (data_o),
    .o_Valid       (valid_o),
    .i_Ready       (ready),
    .o_Last        (last_o),
    .o_ADC_Busy    (busy_o),
    .o_ADC_Done    (done_o),
    .o_Overflow    (ovf_o),
    .o_Drop_Count  (drops_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          l;
    logic [DW-1:0] d;
  } word_t;

  word_t exp_q[$];
  int    checks    = 0;
  int    failures  = 0;
  int    m_phase   = 0;   // 0 idle, 1 capture, 2 drain, 3 done
  int    m_n       = 0;
  int    m_d       = 0;
  int    m_mode    = 0;
  int    m_cyc     = 0;
  int    m_drops   = 0;
  int    m_ovf     = 0;
  int    beats_run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model one cycle: compare what the DUT shows now, then account for the coming edge.
  task automatic step_model();
    int    occ;
    bit    xfer;
    bit    popped_last;
    int    idx;
    word_t w;
    occ = exp_q.size();
    chk("valid", 32'(valid_o), 32'(occ != 0));
    if (occ != 0) begin
      chk("data", 32'(data_o), 32'(exp_q[0].d));
      chk("last", 32'(last_o), 32'(exp_q[0].l));
    end
    chk("busy", 32'(busy_o), 32'(m_phase == 1 || m_phase == 2));
    chk("done", 32'(done_o), 32'(m_phase == 3));
    chk("overflow", 32'(ovf_o), 32'(m_ovf));
    chk("drop_count", 32'(drops_o), 32'(m_drops));
    if (!rst_n) begin
      exp_q.delete();
      m_phase   = 0;
      m_ovf     = 0;
      m_drops   = 0;
      beats_run = 0;
    end else begin
      xfer        = (occ != 0) && ready;
      popped_last = 1'b0;
      if (xfer) begin
        popped_last = exp_q[0].l;
        void'(exp_q.pop_front());
        beats_run++;
      end
      case (m_phase)
        0: begin
          if (work) begin
            m_n       = int'(sample_count);
            m_d       = int'(decim);
            m_mode    = int'(mode);
            m_cyc     = 0;
            m_ovf     = 0;
            m_drops   = 0;
            beats_run = 0;
            m_phase   = (m_n == 0) ? 3 : 1;
          end
        end
        1: begin
          if (m_cyc % (m_d + 1) == 0) begin
            idx = m_cyc / (m_d + 1);
            case (m_mode)
              1:       w.d = 12'h929;
              2:       w.d = DW'(idx);
              default: w.d = cmos_data;
            endcase
            w.l = (idx == m_n - 1);
            if (w.l || occ < DEPTH - 1) begin
              exp_q.push_back(w);
            end else begin
              m_ovf = 1;
              if (m_drops < 65535) m_drops++;
            end
            if (w.l) m_phase = 2;
          end
          m_cyc++;
        end
        2: begin
          if (popped_last) m_phase = 3;
        end
        default: begin
          if (!work) m_phase = 0;
        end
      endcase
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      #2;
      step_model();
    end
  end

  function automatic logic ready_for(input int rmode, input int cyc);
    case (rmode)
      0:       return 1'b1;
      1:       return 1'($urandom_range(0, 1));
      2:       return (cyc >= 45);
      default: return 1'b0;
    endcase
  endfunction

  // One run: start, scramble config and data while it runs, wait (bounded) for done, then release work.
  task automatic run(input int n, input int d, input int m, input int rmode,
                     input int drop_at, input int hold);
    int cyc;
    bit seen;
    @(negedge clk);
    sample_count = CW'(n);
    decim        = 8'(d);
    mode         = 2'(m);
    work         = 1'b1;
    cmos_data    = DW'($urandom);
    ready        = ready_for(rmode, 0);
    seen         = 1'b0;
    cyc          = 0;
    while (!seen && cyc < 3000) begin
      #3;
      if (done_o === 1'b1) begin
        seen = 1'b1;
      end else begin
        @(negedge clk);
        cyc++;
        cmos_data    = DW'($urandom);
        sample_count = CW'($urandom);
        decim        = 8'($urandom);
        mode         = 2'($urandom);
        ready        = ready_for(rmode, cyc);
        if (cyc == drop_at) work = 1'b0;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL run_timeout n=%0d actual=no_done required=done", n);
    end
    repeat (hold) @(negedge clk);
    @(negedge clk);
    work  = 1'b0;
    ready = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin : stim
    rst_n        = 1'b0;
    cmos_data    = {DW{1'b0}};
    work         = 1'b0;
    sample_count = {CW{1'b0}};
    decim        = 8'd0;
    mode         = 2'd0;
    ready        = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #3;
    chk("reset_data", 32'(data_o), 32'd0);
    chk("reset_valid", 32'(valid_o), 32'd0);
    chk("reset_last", 32'(last_o), 32'd0);
    chk("reset_busy", 32'(busy_o), 32'd0);
    chk("reset_done", 32'(done_o), 32'd0);

    // Pattern, N=5, no decimation, always ready.
    run(5, 0, 1, 0, -1, 0);
    chk("pattern_beats", 32'(beats_run), 32'd5);
    chk("pattern_ovf", 32'(ovf_o), 32'd0);

    // Ramp, N=8, Decim=2.
    run(8, 2, 2, 0, -1, 0);
    chk("ramp8_beats", 32'(beats_run), 32'd8);
    chk("ramp8_drops", 32'(drops_o), 32'd0);

    // Ramp, N=40, stream stalled through the whole capture.
    run(40, 0, 2, 2, -1, 0);
    chk("ramp40_beats", 32'(beats_run), 32'd16);
    chk("ramp40_ovf", 32'(ovf_o), 32'd1);
    chk("ramp40_drops", 32'(drops_o), 32'd24);

    // Live, N=4, random ready, done held for a while with work still high.
    run(4, 0, 0, 1, -1, 3);
    chk("live_beats", 32'(beats_run), 32'd4);

    // N=0: straight to done, no data.
    run(0, 0, 1, 0, -1, 2);
    chk("n0_beats", 32'(beats_run), 32'd0);

    // Work dropped mid-capture: run still completes.
    run(6, 1, 2, 0, 3, 0);
    chk("dropwork_beats", 32'(beats_run), 32'd6);

    // Reset during drain with three words queued.
    @(negedge clk);
    sample_count = 20'd3;
    decim        = 8'd0;
    mode         = 2'd2;
    work         = 1'b1;
    ready        = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #3;
    chk("pre_rst_valid", 32'(valid_o), 32'd1);
    chk("pre_rst_busy", 32'(busy_o), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    work  = 1'b0;
    ready = 1'b1;
    #3;
    chk("post_rst_valid", 32'(valid_o), 32'd0);
    chk("post_rst_busy", 32'(busy_o), 32'd0);
    chk("post_rst_done", 32'(done_o), 32'd0);
    chk("post_rst_ovf", 32'(ovf_o), 32'd0);
    chk("post_rst_data", 32'(data_o), 32'd0);
    run(10, 0, 2, 1, -1, 0);
    chk("post_rst_run_beats", 32'(beats_run), 32'd10);

    // Randomized runs.
    for (int r = 0; r < 8; r++) begin
      run(int'($urandom_range(1, 40)), int'($urandom_range(0, 3)),
          int'($urandom_range(0, 3)), 1, -1, int'($urandom_range(0, 2)));
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
